// File: rtl/tile_buffer_bank.sv
// Multi-bank tile staging buffer: per-bank fill/replay state, valid/ready handshakes on both sides.
// Optional sticky protocol-error flag enabled by defining TILE_BUFFER_BANK_ERR_EN.
module tile_buffer_bank #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned TILE_SIZE    = 32,
    parameter int unsigned DEPTH_TILES  = 4,
    parameter int unsigned BUFFER_COUNT = 2,
    localparam int unsigned TILE_WIDTH  = TILE_SIZE * DATA_WIDTH,
    localparam int unsigned BW          = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
    localparam int unsigned LW          = $clog2(DEPTH_TILES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    input  logic [BW-1:0]           wr_buf,
    input  logic [LW-1:0]           wr_len,
    input  logic [TILE_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    output logic                    wr_done,
    input  logic                    rd_valid,
    input  logic [BW-1:0]           rd_buf,
    output logic                    rd_ready,
    output logic [TILE_WIDTH-1:0]   rd_data,
    output logic                    rd_data_valid,
    output logic                    rd_last,
    output logic                    rd_done,
    output logic [BUFFER_COUNT-1:0] bank_full,
    output logic                    err
);

    localparam int unsigned PW = (DEPTH_TILES > 1) ? $clog2(DEPTH_TILES) : 1;
    localparam logic [BW:0] BUF_LIMIT = (BW + 1)'(BUFFER_COUNT);
    localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH_TILES);

    typedef enum logic [1:0] {StEmpty, StWriting, StValid, StReading} bank_state_e;

    bank_state_e         state_q  [BUFFER_COUNT];
    bank_state_e         state_d  [BUFFER_COUNT];
    logic [PW-1:0]       wr_ptr_q [BUFFER_COUNT];
    logic [PW-1:0]       wr_ptr_d [BUFFER_COUNT];
    logic [PW-1:0]       rd_ptr_q [BUFFER_COUNT];
    logic [PW-1:0]       rd_ptr_d [BUFFER_COUNT];
    logic [LW-1:0]       len_q    [BUFFER_COUNT];
    logic [LW-1:0]       len_d    [BUFFER_COUNT];

    // Storage has no reset so it can map onto RAM.
    logic [TILE_WIDTH-1:0] mem [BUFFER_COUNT][DEPTH_TILES];

    logic                  wr_in_range, rd_in_range;
    logic [BW-1:0]         wr_idx, rd_idx;
    logic                  wr_fire, rd_fire;
    logic                  wr_first, wr_last, rd_last_tile;
    logic [LW-1:0]         wr_eff_len;
    logic [PW-1:0]         wr_addr;
    logic                  wr_done_q, rd_data_valid_q, rd_last_q;
    logic [TILE_WIDTH-1:0] rd_data_q;

    always_comb begin
        wr_in_range = {1'b0, wr_buf} < BUF_LIMIT;
        rd_in_range = {1'b0, rd_buf} < BUF_LIMIT;
        wr_idx      = wr_in_range ? wr_buf : '0;
        rd_idx      = rd_in_range ? rd_buf : '0;

        wr_ready = wr_in_range && (state_q[wr_idx] != StReading);
        // A write to the same bank always takes priority over a read request.
        rd_ready = rd_in_range
                   && ((state_q[rd_idx] == StValid) || (state_q[rd_idx] == StReading))
                   && !(wr_valid && (wr_buf == rd_buf));
        wr_fire  = wr_valid && wr_ready;
        rd_fire  = rd_valid && rd_ready;

        wr_eff_len = ((wr_len == '0) || (wr_len > MAX_LEN)) ? MAX_LEN : wr_len;
        wr_first   = (state_q[wr_idx] == StEmpty) || (state_q[wr_idx] == StValid);
        wr_addr    = wr_first ? '0 : wr_ptr_q[wr_idx];
        wr_last    = wr_first ? (wr_eff_len == LW'(1))
                              : (LW'(wr_ptr_q[wr_idx]) == len_q[wr_idx] - LW'(1));
        rd_last_tile = LW'(rd_ptr_q[rd_idx]) == len_q[rd_idx] - LW'(1);
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;

        if (wr_fire) begin
            if (wr_first) begin
                len_d[wr_idx]    = wr_eff_len;
                rd_ptr_d[wr_idx] = '0;
            end
            if (wr_last) begin
                state_d[wr_idx]  = StValid;
                wr_ptr_d[wr_idx] = '0;
            end else begin
                state_d[wr_idx]  = StWriting;
                wr_ptr_d[wr_idx] = wr_addr + PW'(1);
            end
        end

        if (rd_fire) begin
            if (rd_last_tile) begin
                state_d[rd_idx]  = StValid;
                rd_ptr_d[rd_idx] = '0;
            end else begin
                state_d[rd_idx]  = StReading;
                rd_ptr_d[rd_idx] = rd_ptr_q[rd_idx] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned b = 0; b < BUFFER_COUNT; b++) begin
                state_q[b]  <= StEmpty;
                wr_ptr_q[b] <= '0;
                rd_ptr_q[b] <= '0;
                len_q[b]    <= '0;
            end
            wr_done_q       <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_last_q       <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            len_q           <= len_d;
            wr_done_q       <= wr_fire && wr_last;
            rd_data_valid_q <= rd_fire;
            rd_last_q       <= rd_fire && rd_last_tile;
            if (rd_fire) begin
                rd_data_q <= mem[rd_idx][rd_ptr_q[rd_idx]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_idx][wr_addr] <= wr_data;
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < BUFFER_COUNT; b++) begin
            bank_full[b] = (state_q[b] == StValid) || (state_q[b] == StReading);
        end
    end

    assign wr_done       = wr_done_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign rd_last       = rd_last_q;
    assign rd_done       = rd_last_q;

`ifdef TILE_BUFFER_BANK_ERR_EN
    logic err_q, err_set;

    always_comb begin
        err_set = (wr_valid && !wr_in_range)
                  || (rd_valid && !rd_in_range)
                  || (rd_valid && rd_in_range
                      && ((state_q[rd_idx] == StEmpty) || (state_q[rd_idx] == StWriting)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tile_buffer_bank.sv
// Self-checking bench for tile_buffer_bank: directed scenarios plus randomized traffic
// checked against a tile-level reference model.
module tb_tile_buffer_bank;

    localparam int DW = 8, TS = 32, DT = 4, NB = 2, TW = TS * DW;
    localparam int TS3 = 4, TW3 = TS3 * DW;
`ifdef TILE_BUFFER_BANK_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid, wr_ready, wr_done, rd_valid, rd_ready;
    logic [0:0]    wr_buf, rd_buf;
    logic [2:0]    wr_len;
    logic [TW-1:0] wr_data, rd_data;
    logic          rd_data_valid, rd_last, rd_done, err;
    logic [1:0]    bank_full;

    logic           wr_valid3, wr_ready3, wr_done3, rd_valid3, rd_ready3;
    logic [1:0]     wr_buf3, rd_buf3;
    logic [2:0]     wr_len3;
    logic [TW3-1:0] wr_data3, rd_data3;
    logic           rd_data_valid3, rd_last3, rd_done3, err3;
    logic [2:0]     bank_full3;

    always #5 clk = ~clk;

    tile_buffer_bank #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .DEPTH_TILES(DT), .BUFFER_COUNT(NB)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_buf(wr_buf), .wr_len(wr_len),
        .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done), .rd_valid(rd_valid),
        .rd_buf(rd_buf), .rd_ready(rd_ready), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .rd_last(rd_last), .rd_done(rd_done), .bank_full(bank_full), .err(err)
    );

    tile_buffer_bank #(.DATA_WIDTH(DW), .TILE_SIZE(TS3), .DEPTH_TILES(4), .BUFFER_COUNT(3)) dut3 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid3), .wr_buf(wr_buf3), .wr_len(wr_len3),
        .wr_data(wr_data3), .wr_ready(wr_ready3), .wr_done(wr_done3), .rd_valid(rd_valid3),
        .rd_buf(rd_buf3), .rd_ready(rd_ready3), .rd_data(rd_data3),
        .rd_data_valid(rd_data_valid3), .rd_last(rd_last3), .rd_done(rd_done3),
        .bank_full(bank_full3), .err(err3)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: committed tile contents, fill progress and replay cursor per bank.
    logic [TW-1:0] m_mem [NB][DT];
    int            m_len [NB];
    int            m_wpos[NB];
    int            m_rpos[NB];
    bit            m_valid[NB];
    bit            m_err;

    logic [TW-1:0] exp_data;
    bit            exp_wr_ready, exp_rd_ready, exp_wr_done, exp_dv, exp_last;
    logic [1:0]    exp_full;
    logic          obs_wr_ready, obs_rd_ready;

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            m_len[b] = 0; m_wpos[b] = 0; m_rpos[b] = 0; m_valid[b] = 1'b0;
        end
        m_err = 1'b0; exp_data = '0; exp_wr_done = 1'b0; exp_dv = 1'b0; exp_last = 1'b0;
        exp_full = 2'b00;
    endfunction

    function automatic logic [TW-1:0] rand_tile();
        logic [TW-1:0] t;
        for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // Advance one clock with the inputs already driven; sample readies mid-cycle.
    task automatic tick();
        int  wb, rb;
        bit  wacc, racc;
        wb = int'(wr_buf);
        rb = int'(rd_buf);
        @(negedge clk);
        obs_wr_ready = wr_ready;
        obs_rd_ready = rd_ready;
        exp_wr_ready = (m_rpos[wb] == 0);
        exp_rd_ready = m_valid[rb] && !(wr_valid && (wb == rb));
        wacc = wr_valid && exp_wr_ready;
        racc = rd_valid && exp_rd_ready;
        if (ERR_ON && rd_valid && !m_valid[rb]) m_err = 1'b1;
        exp_wr_done = 1'b0;
        exp_dv      = racc;
        exp_last    = 1'b0;
        if (racc) begin
            exp_data = m_mem[rb][m_rpos[rb]];
            m_rpos[rb]++;
            if (m_rpos[rb] == m_len[rb]) begin
                exp_last   = 1'b1;
                m_rpos[rb] = 0;
            end
        end
        if (wacc) begin
            if (m_wpos[wb] == 0) begin
                m_len[wb]   = ((wr_len == 0) || (int'(wr_len) > DT)) ? DT : int'(wr_len);
                m_valid[wb] = 1'b0;
                m_rpos[wb]  = 0;
            end
            m_mem[wb][m_wpos[wb]] = wr_data;
            m_wpos[wb]++;
            if (m_wpos[wb] == m_len[wb]) begin
                m_wpos[wb]  = 0;
                m_valid[wb] = 1'b1;
                exp_wr_done = 1'b1;
            end
        end
        for (int b = 0; b < NB; b++) exp_full[b] = m_valid[b];
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_buf = '0; wr_len = '0; wr_data = '0; rd_valid = 1'b0; rd_buf = '0;
        wr_valid3 = 1'b0; wr_buf3 = '0; wr_len3 = '0; wr_data3 = '0; rd_valid3 = 1'b0;
        rd_buf3 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset wr_ready: got %b want 1", wr_ready); end
        vectors++; if (rd_ready !== 1'b0) begin miscompares++; $display("FAIL reset rd_ready: got %b want 0", rd_ready); end
        vectors++; if ({wr_done, rd_data_valid, rd_last, rd_done} !== 4'b0) begin miscompares++; $display("FAIL reset pulses: got %b want 0000", {wr_done, rd_data_valid, rd_last, rd_done}); end
        vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset rd_data: got %h want 0", rd_data); end
        vectors++; if (bank_full !== 2'b00 || bank_full3 !== 3'b000) begin miscompares++; $display("FAIL reset bank_full: got %b/%b want 0/0", bank_full, bank_full3); end
        vectors++; if (err !== 1'b0 || err3 !== 1'b0) begin miscompares++; $display("FAIL reset err: got %b/%b want 0/0", err, err3); end
        reset = 1'b0;
    endtask

    task automatic test_fill_read();
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_buf = 1'b0; wr_len = 3'd0; wr_data = {TS{8'(8'h10 + k)}};
            tick();
            vectors++; if (obs_wr_ready !== exp_wr_ready) begin miscompares++; $display("FAIL fill wr_ready beat %0d: got %b want %b", k, obs_wr_ready, exp_wr_ready); end
            vectors++; if (wr_done !== exp_wr_done) begin miscompares++; $display("FAIL fill wr_done beat %0d: got %b want %b", k, wr_done, exp_wr_done); end
        end
        wr_valid = 1'b0;
        vectors++; if (bank_full !== 2'b01) begin miscompares++; $display("FAIL fill bank_full: got %b want 01", bank_full); end
        for (int k = 0; k < 4; k++) begin
            rd_valid = 1'b1; rd_buf = 1'b0;
            tick();
            vectors++; if (obs_rd_ready !== exp_rd_ready) begin miscompares++; $display("FAIL read rd_ready tile %0d: got %b want %b", k, obs_rd_ready, exp_rd_ready); end
            vectors++; if (rd_data_valid !== exp_dv || rd_data !== exp_data) begin miscompares++; $display("FAIL read data tile %0d: got %b/%h want %b/%h", k, rd_data_valid, rd_data, exp_dv, exp_data); end
            vectors++; if (rd_data[7:0] !== 8'(8'h10 + k)) begin miscompares++; $display("FAIL read byte0 tile %0d: got %h want %h", k, rd_data[7:0], 8'(8'h10 + k)); end
            vectors++; if (rd_last !== exp_last || rd_done !== exp_last) begin miscompares++; $display("FAIL read last tile %0d: got %b/%b want %b", k, rd_last, rd_done, exp_last); end
        end
        rd_valid = 1'b0;
        tick();
        vectors++; if (rd_data_valid !== 1'b0 || rd_data !== exp_data) begin miscompares++; $display("FAIL read hold: got %b/%h want 0/%h", rd_data_valid, rd_data, exp_data); end
    endtask

    task automatic test_ping_pong();
        for (int k = 0; k < 4; k++) begin
            rd_valid = 1'b1; rd_buf = 1'b0;
            wr_valid = (k < 2); wr_buf = 1'b1; wr_len = 3'd2; wr_data = rand_tile();
            tick();
            vectors++; if (obs_rd_ready !== exp_rd_ready || obs_wr_ready !== exp_wr_ready) begin miscompares++; $display("FAIL pingpong ready cyc %0d: got %b%b want %b%b", k, obs_rd_ready, obs_wr_ready, exp_rd_ready, exp_wr_ready); end
            vectors++; if (rd_data !== exp_data || rd_last !== exp_last) begin miscompares++; $display("FAIL pingpong read cyc %0d: got %h/%b want %h/%b", k, rd_data, rd_last, exp_data, exp_last); end
            vectors++; if (wr_done !== exp_wr_done) begin miscompares++; $display("FAIL pingpong wr_done cyc %0d: got %b want %b", k, wr_done, exp_wr_done); end
        end
        rd_valid = 1'b0; wr_valid = 1'b0;
        vectors++; if (bank_full !== 2'b11) begin miscompares++; $display("FAIL pingpong bank_full: got %b want 11", bank_full); end
    endtask

    task automatic test_replay();
        int dones = 0;
        for (int k = 0; k < 8; k++) begin
            rd_valid = 1'b1; rd_buf = 1'b0;
            tick();
            if (rd_done === 1'b1) dones++;
            vectors++; if (obs_rd_ready !== exp_rd_ready || rd_data !== exp_data || rd_last !== exp_last) begin miscompares++; $display("FAIL replay tile %0d: got %b/%h/%b want %b/%h/%b", k, obs_rd_ready, rd_data, rd_last, exp_rd_ready, exp_data, exp_last); end
        end
        rd_valid = 1'b0;
        vectors++; if (dones !== 2) begin miscompares++; $display("FAIL replay rd_done count: got %0d want 2", dones); end
        vectors++; if (bank_full !== 2'b11) begin miscompares++; $display("FAIL replay bank_full: got %b want 11", bank_full); end
    endtask

    task automatic test_conflict();
        wr_valid = 1'b1; wr_buf = 1'b0; wr_len = 3'd3; wr_data = rand_tile();
        rd_valid = 1'b1; rd_buf = 1'b0;
        tick();
        vectors++; if (obs_rd_ready !== exp_rd_ready || obs_wr_ready !== exp_wr_ready) begin miscompares++; $display("FAIL conflict ready: got rd %b wr %b want rd %b wr %b", obs_rd_ready, obs_wr_ready, exp_rd_ready, exp_wr_ready); end
        vectors++; if (bank_full !== exp_full) begin miscompares++; $display("FAIL conflict bank_full: got %b want %b", bank_full, exp_full); end
        rd_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            wr_data = rand_tile();
            tick();
            vectors++; if (wr_done !== exp_wr_done) begin miscompares++; $display("FAIL conflict refill done beat %0d: got %b want %b", k, wr_done, exp_wr_done); end
        end
        wr_valid = 1'b0; rd_valid = 1'b1; rd_buf = 1'b1;
        tick();
        rd_valid = 1'b0; wr_valid = 1'b1; wr_buf = 1'b1; wr_len = 3'd1; wr_data = rand_tile();
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++; if (obs_wr_ready !== exp_wr_ready) begin miscompares++; $display("FAIL conflict reading bank wr_ready cyc %0d: got %b want %b", k, obs_wr_ready, exp_wr_ready); end
        end
        wr_valid = 1'b0; rd_valid = 1'b1; rd_buf = 1'b1;
        tick();
        vectors++; if (rd_done !== exp_last || rd_data !== exp_data) begin miscompares++; $display("FAIL conflict rd_done: got %b/%h want %b/%h", rd_done, rd_data, exp_last, exp_data); end
        rd_valid = 1'b0; wr_valid = 1'b1; wr_buf = 1'b1; wr_len = 3'd1; wr_data = rand_tile();
        tick();
        vectors++; if (obs_wr_ready !== exp_wr_ready || wr_done !== exp_wr_done) begin miscompares++; $display("FAIL conflict single-tile write: got %b/%b want %b/%b", obs_wr_ready, wr_done, exp_wr_ready, exp_wr_done); end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr_valid = 1'b1; wr_buf = 1'b0; wr_len = 3'd3;
        for (int k = 0; k < 2; k++) begin
            wr_data = rand_tile();
            tick();
        end
        wr_valid = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1;
        vectors++; if (bank_full !== 2'b00 || rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL midreset async clear: got %b/%b want 00/0", bank_full, rd_data_valid); end
        @(posedge clk);
        #1;
        vectors++; if (wr_done !== 1'b0) begin miscompares++; $display("FAIL midreset wr_done: got %b want 0", wr_done); end
        reset = 1'b0;
        rd_valid = 1'b1; rd_buf = 1'b0;
        tick();
        vectors++; if (obs_rd_ready !== exp_rd_ready) begin miscompares++; $display("FAIL midreset rd_ready: got %b want %b", obs_rd_ready, exp_rd_ready); end
        vectors++; if (err !== m_err) begin miscompares++; $display("FAIL midreset err: got %b want %b", err, m_err); end
        rd_valid = 1'b0;
    endtask

    task automatic test_bad_bank();
        logic [TW3-1:0] t;
        t = TW3'($urandom);
        wr_valid3 = 1'b1; wr_buf3 = 2'd3; wr_len3 = 3'd1; wr_data3 = t;
        @(negedge clk);
        vectors++; if (wr_ready3 !== 1'b0) begin miscompares++; $display("FAIL badbank wr_ready: got %b want 0", wr_ready3); end
        @(posedge clk); #1;
        vectors++; if (err3 !== ERR_ON || bank_full3 !== 3'b000) begin miscompares++; $display("FAIL badbank err/full: got %b/%b want %b/000", err3, bank_full3, ERR_ON); end
        wr_buf3 = 2'd2;
        @(negedge clk);
        vectors++; if (wr_ready3 !== 1'b1) begin miscompares++; $display("FAIL bank2 wr_ready: got %b want 1", wr_ready3); end
        @(posedge clk); #1;
        vectors++; if (wr_done3 !== 1'b1 || bank_full3 !== 3'b100) begin miscompares++; $display("FAIL bank2 fill: got %b/%b want 1/100", wr_done3, bank_full3); end
        wr_valid3 = 1'b0; rd_valid3 = 1'b1; rd_buf3 = 2'd2;
        @(posedge clk); #1;
        vectors++; if (rd_data3 !== t || rd_last3 !== 1'b1 || rd_done3 !== 1'b1) begin miscompares++; $display("FAIL bank2 read: got %h/%b/%b want %h/1/1", rd_data3, rd_last3, rd_done3, t); end
        rd_valid3 = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            wr_valid = ($urandom_range(0, 2) != 0); wr_buf = 1'($urandom);
            wr_len = 3'($urandom); wr_data = rand_tile();
            rd_valid = ($urandom_range(0, 2) != 0); rd_buf = 1'($urandom);
            tick();
            vectors++; if (obs_wr_ready !== exp_wr_ready || obs_rd_ready !== exp_rd_ready) begin miscompares++; $display("FAIL random ready cyc %0d: got wr %b rd %b want wr %b rd %b", k, obs_wr_ready, obs_rd_ready, exp_wr_ready, exp_rd_ready); end
            vectors++; if (wr_done !== exp_wr_done || rd_data_valid !== exp_dv || rd_last !== exp_last || rd_done !== exp_last) begin miscompares++; $display("FAIL random pulses cyc %0d: got %b%b%b%b want %b%b%b%b", k, wr_done, rd_data_valid, rd_last, rd_done, exp_wr_done, exp_dv, exp_last, exp_last); end
            vectors++; if (rd_data !== exp_data) begin miscompares++; $display("FAIL random rd_data cyc %0d: got %h want %h", k, rd_data, exp_data); end
            vectors++; if (bank_full !== exp_full || err !== m_err) begin miscompares++; $display("FAIL random full/err cyc %0d: got %b/%b want %b/%b", k, bank_full, err, exp_full, m_err); end
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_ping_pong();
        test_replay();
        test_conflict();
        test_reset_mid();
        test_bad_bank();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
